// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: green -> yellow -> all-red per road,
// driving an external green timer and honouring emergency preemption.
module traffic_phase_ctrl #(
  parameter int unsigned YELLOW_TIME = 4,
  parameter int unsigned ALLRED_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_ns,
  input  logic       sensor_ew,
  input  logic       emerg,
  input  logic       timer_expired,
  output logic       timer_clr,
  output logic       timer_start,
  output logic       timer_extend,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic [2:0] phase
);

  // Green timer interface: timer_clr pulses once on green entry, then
  // timer_start holds high until we leave green; timer_expired is only
  // honoured after the clear cycle.

  typedef enum logic [2:0] {
    RED_A     = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_B     = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  localparam logic [7:0] Y_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] A_LAST = 8'(ALLRED_TIME - 1);

  state_t     state;
  state_t     nxt;
  logic [7:0] cnt;
  logic [7:0] term;
  logic       first;
  logic       nxt_green;
  logic       entering;
  logic       counting;
  logic [1:0] ns_nxt;
  logic [1:0] ew_nxt;

  always_comb begin
    nxt = state;
    case (state)
      RED_A:     if (cnt == A_LAST && !emerg) nxt = NS_GREEN;
      NS_GREEN:  if (emerg || (timer_expired && !first)) nxt = NS_YELLOW;
      NS_YELLOW: if (cnt == Y_LAST) nxt = RED_B;
      RED_B:     if (cnt == A_LAST && !emerg) nxt = EW_GREEN;
      EW_GREEN:  if (emerg || (timer_expired && !first)) nxt = EW_YELLOW;
      EW_YELLOW: if (cnt == Y_LAST) nxt = RED_A;
      default:   nxt = RED_A;
    endcase
  end

  always_comb begin
    term      = (state == NS_YELLOW || state == EW_YELLOW) ? Y_LAST : A_LAST;
    counting  = (state != NS_GREEN) && (state != EW_GREEN);
    nxt_green = (nxt == NS_GREEN) || (nxt == EW_GREEN);
    entering  = nxt_green && (nxt != state);
    ns_nxt    = LAMP_RED;
    ew_nxt    = LAMP_RED;
    case (nxt)
      NS_GREEN:  ns_nxt = LAMP_GREEN;
      NS_YELLOW: ns_nxt = LAMP_YELLOW;
      EW_GREEN:  ew_nxt = LAMP_GREEN;
      EW_YELLOW: ew_nxt = LAMP_YELLOW;
      default: begin
        ns_nxt = LAMP_RED;
        ew_nxt = LAMP_RED;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe, with no input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RED_A;
      cnt          <= 8'd0;
      first        <= 1'b0;
      timer_clr    <= 1'b0;
      timer_start  <= 1'b0;
      timer_extend <= 1'b0;
      ns_light     <= LAMP_RED;
      ew_light     <= LAMP_RED;
      phase        <= 3'd0;
    end else begin
      state       <= nxt;
      phase       <= nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
      first       <= entering;
      timer_clr   <= entering;
      timer_start <= nxt_green && !entering;
      if (nxt != state)
        cnt <= 8'd0;
      else if (counting && cnt != term)
        cnt <= cnt + 8'd1;
      // Extension decision is frozen at entry using the sensors seen on that edge.
      if (entering)
        timer_extend <= (nxt == NS_GREEN) ? (sensor_ns & ~sensor_ew)
                                          : (sensor_ew & ~sensor_ns);
      else if (!nxt_green)
        timer_extend <= 1'b0;
    end
  end

endmodule
